// File: rtl/io_bus_sequencer.sv
// CPU-to-peripheral I/O bus sequencer with a masked, prioritised interrupt aggregator.
// Optional feature: define IOBUS_IRQ_STICKY_EN for edge-captured, read-to-clear pending bits.
module io_bus_sequencer #(
    parameter int          NUM_DEV      = 4,
    parameter int          WAIT_CYCLES  = 0,
    parameter logic [31:0] UNMAPPED_DAT = 32'h0000_00EA
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic               iReq,
    input  logic               iWe,
    input  logic [5:0]         iAddr,
    input  logic [31:0]        iWData,
    output logic [31:0]        oRData,
    output logic               oAck,
    output logic [1:0]         oPerAddr,
    output logic               oPerWrite,
    output logic [NUM_DEV-1:0] oPerEnable,
    inout  wire  [31:0]        bPerData,
    input  logic [NUM_DEV-1:0] iPerInt,
    output logic               oIrq,
    output logic [3:0]         oIrqVec
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_ACK} state_t;

    localparam logic [4:0] NUM_DEV_W = 5'(NUM_DEV);
    localparam logic [2:0] LAST_WAIT = 3'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [5:0]          addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [2:0]          wait_q, wait_d;
    logic [NUM_DEV-1:0]  mask_q, mask_d;
    logic                irq_q, irq_d;
    logic [3:0]          vec_q, vec_d;
    logic [NUM_DEV-1:0]  pending;
    logic [NUM_DEV-1:0]  masked;
    logic [31:0]         int_rdata;
    logic                drive;
    logic [3:0]          dev;
    logic [1:0]          reg_idx;
    logic                mapped;
    logic                internal;

    assign dev      = addr_q[5:2];
    assign reg_idx  = addr_q[1:0];
    assign mapped   = {1'b0, dev} < NUM_DEV_W;
    assign internal = (dev == 4'hF);

    // The controller only ever drives the shared bus while a write is in flight.
    assign bPerData = drive ? wdata_q : 'z;

    assign oRData  = rdata_q;
    assign oIrq    = irq_q;
    assign oIrqVec = vec_q;

`ifdef IOBUS_IRQ_STICKY_EN
    logic [NUM_DEV-1:0] int_prev_q;
    logic [NUM_DEV-1:0] pend_q, pend_d;
    logic               pend_clr;

    always_comb begin
        pend_clr = (state_q == S_ACK) && !we_q && internal && (reg_idx == 2'd0);
        // Rising edges are ORed in after the clear so a coincident set wins.
        pend_d   = (pend_q & ~{NUM_DEV{pend_clr}}) | (iPerInt & ~int_prev_q);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            int_prev_q <= '0;
            pend_q     <= '0;
        end else begin
            int_prev_q <= iPerInt;
            pend_q     <= pend_d;
        end
    end

    assign pending = pend_q;
`else
    assign pending = iPerInt;
`endif

    always_comb begin
        case (reg_idx)
            2'd0:    int_rdata = 32'(pending);
            2'd1:    int_rdata = 32'(mask_q);
            default: int_rdata = '0;
        endcase
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        wait_d     = wait_q;
        mask_d     = mask_q;
        oAck       = 1'b0;
        oPerAddr   = 2'd0;
        oPerWrite  = 1'b0;
        oPerEnable = '0;
        drive      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iReq) begin
                    we_d    = iWe;
                    addr_d  = iAddr;
                    wdata_d = iWData;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                oPerAddr  = reg_idx;
                oPerWrite = we_q;
                drive     = we_q;
                wait_d    = '0;
                state_d   = S_STROBE;
            end
            S_STROBE: begin
                oPerAddr  = reg_idx;
                oPerWrite = we_q;
                drive     = we_q;
                for (int i = 0; i < NUM_DEV; i++) begin
                    oPerEnable[i] = mapped && (dev == 4'(i));
                end
                if (wait_q == LAST_WAIT) begin
                    state_d = S_ACK;
                    if (!we_q) begin
                        rdata_d = internal ? int_rdata : (mapped ? bPerData : UNMAPPED_DAT);
                    end else if (internal && (reg_idx == 2'd1)) begin
                        mask_d = wdata_q[NUM_DEV-1:0];
                    end
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_ACK: begin
                oAck    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        masked = pending & mask_q;
        irq_d  = |masked;
        vec_d  = 4'd0;
        // Scan downwards so the lowest set index is the one left standing.
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if (masked[i]) vec_d = 4'(i);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
            mask_q  <= '0;
            irq_q   <= 1'b0;
            vec_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            wait_q  <= wait_d;
            mask_q  <= mask_d;
            irq_q   <= irq_d;
            vec_q   <= vec_d;
        end
    end

endmodule

// File: tb/tb_io_bus_sequencer.sv
// Self-checking bench for io_bus_sequencer: two instances (WAIT_CYCLES 0 and 3), a peripheral
// register model on each bus, and a spec-level reference for read data, strobes and interrupts.
module tb_io_bus_sequencer;

    localparam int ND = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pm_init;

    logic        req   [2];
    logic        we    [2];
    logic [5:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [ND-1:0] pint [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic [1:0]  paddr [2];
    logic        pwrite[2];
    logic [ND-1:0] pen [2];
    logic        irq   [2];
    logic [3:0]  vec   [2];
    wire  [31:0] bus0;
    wire  [31:0] bus1;

    logic [31:0] pmem [2][ND][4];
    logic        pdrv [2];
    logic [31:0] pdat [2];

    logic [31:0]   ref_mem  [2][ND][4];
    logic [ND-1:0] ref_mask [2];
    logic [ND-1:0] ref_pend [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_bus_sequencer #(.NUM_DEV(ND), .WAIT_CYCLES(0), .UNMAPPED_DAT(32'h0000_00EA)) u0 (
        .iClk(clk), .iRst(rst), .iReq(req[0]), .iWe(we[0]), .iAddr(addr[0]),
        .iWData(wdata[0]), .oRData(rdata[0]), .oAck(ack[0]), .oPerAddr(paddr[0]),
        .oPerWrite(pwrite[0]), .oPerEnable(pen[0]), .bPerData(bus0), .iPerInt(pint[0]),
        .oIrq(irq[0]), .oIrqVec(vec[0])
    );

    io_bus_sequencer #(.NUM_DEV(ND), .WAIT_CYCLES(3), .UNMAPPED_DAT(32'h0000_00EA)) u1 (
        .iClk(clk), .iRst(rst), .iReq(req[1]), .iWe(we[1]), .iAddr(addr[1]),
        .iWData(wdata[1]), .oRData(rdata[1]), .oAck(ack[1]), .oPerAddr(paddr[1]),
        .oPerWrite(pwrite[1]), .oPerEnable(pen[1]), .bPerData(bus1), .iPerInt(pint[1]),
        .oIrq(irq[1]), .oIrqVec(vec[1])
    );

    function automatic logic [31:0] init_val(int s, int d, int r);
        return 32'hC0DE_0000 + 32'(s * 256 + d * 16 + r);
    endfunction

    // Peripheral register file: captures on enabled write strobes, drives on enabled reads.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++)
            for (int d = 0; d < ND; d++)
                for (int r = 0; r < 4; r++)
                    if (pm_init)
                        pmem[s][d][r] <= init_val(s, d, r);
                    else if (pen[s][d] && pwrite[s] && paddr[s] == 2'(r))
                        pmem[s][d][r] <= (s == 0) ? bus0 : bus1;
    end

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            pdrv[s] = 1'b0;
            pdat[s] = '0;
            for (int d = 0; d < ND; d++) begin
                if (pen[s][d] && !pwrite[s]) begin
                    pdrv[s] = 1'b1;
                    pdat[s] = pmem[s][d][paddr[s]];
                end
            end
        end
    end

    assign bus0 = pdrv[0] ? pdat[0] : 'z;
    assign bus1 = pdrv[1] ? pdat[1] : 'z;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [ND-1:0] cur_pend(int s);
`ifdef IOBUS_IRQ_STICKY_EN
        return ref_pend[s];
`else
        return pint[s];
`endif
    endfunction

    function automatic logic [31:0] exp_read(int s, logic [5:0] a);
        int d = int'(a[5:2]);
        if (d < ND) return ref_mem[s][d][a[1:0]];
        if (d != 15) return 32'h0000_00EA;
        case (a[1:0])
            2'd0:    return 32'(cur_pend(s));
            2'd1:    return 32'(ref_mask[s]);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] lowest(logic [ND-1:0] v);
        logic [3:0] r = 4'd0;
        for (int i = ND - 1; i >= 0; i--) if (v[i]) r = 4'(i);
        return r;
    endfunction

    task automatic set_int(input int s, input logic [ND-1:0] v);
        @(negedge clk);
        ref_pend[s] = ref_pend[s] | (v & ~pint[s]);
        pint[s] = v;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_irq(input int s, input string tag);
        logic [ND-1:0] m = ref_mask[s] & cur_pend(s);
        check({tag, "_irq"}, irq[s], |m);
        check({tag, "_vec"}, vec[s], lowest(m));
    endtask

    // One CPU access; the ack is expected on the (2+wt)th edge after the sampling edge,
    // i.e. the oAck cycle is the (3+wt)th cycle after the edge that samples iReq.
    task automatic xact(input int s, input logic w, input logic [5:0] a,
                        input logic [31:0] d, input int wt);
        int dev = int'(a[5:2]);
        int k = 99;
        int strobes = 0;
        logic seen = 1'b0;
        logic en_bad = 1'b0, ctl_bad = 1'b0, bus_bad = 1'b0;
        logic [ND-1:0] exp_en = '0;
        logic [31:0] exp_r = exp_read(s, a);
        logic [31:0] busv;
        if (dev < ND) exp_en[dev] = 1'b1;
        @(negedge clk);
        req[s] = 1'b1; we[s] = w; addr[s] = a; wdata[s] = d;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (pen[s] != '0) begin
                strobes++;
                if (pen[s] !== exp_en) en_bad = 1'b1;
                if (pwrite[s] !== w || paddr[s] !== a[1:0]) ctl_bad = 1'b1;
                busv = (s == 0) ? bus0 : bus1;
                if (w && busv !== d) bus_bad = 1'b1;
            end
            if (ack[s] === 1'b1) begin
                seen = 1'b1;
                k = i;
            end
        end
        req[s] = 1'b0;
        check("ack_latency", k, 2 + wt);
        check("strobe_count", strobes, (dev < ND) ? wt + 1 : 0);
        check("strobe_enable", en_bad, 0);
        check("strobe_ctl", ctl_bad, 0);
        if (w) check("write_bus", bus_bad, 0);
        else   check("read_data", rdata[s], exp_r);
        @(posedge clk); #1;
        check("ack_pulse", ack[s], 0);
        if (w && dev < ND) ref_mem[s][dev][a[1:0]] = d;
        if (w && dev == 15 && a[1:0] == 2'd1) ref_mask[s] = d[ND-1:0];
        if (!w && dev == 15 && a[1:0] == 2'd0) ref_pend[s] = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        logic [5:0]  ra;
        logic        rw;
        logic [31:0] rd;

        rst = 1'b1;
        pm_init = 1'b1;
        for (int s = 0; s < 2; s++) begin
            req[s] = 0; we[s] = 0; addr[s] = '0; wdata[s] = '0; pint[s] = '0;
            ref_mask[s] = '0; ref_pend[s] = '0;
            for (int d = 0; d < ND; d++)
                for (int r = 0; r < 4; r++) ref_mem[s][d][r] = init_val(s, d, r);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            check("rst_ack", ack[s], 0);
            check("rst_en", pen[s], 0);
            check("rst_write", pwrite[s], 0);
            check("rst_addr", paddr[s], 0);
            check("rst_rdata", rdata[s], 0);
            check("rst_irq", irq[s], 0);
            check("rst_vec", vec[s], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        pm_init = 1'b0;

        // Directed accesses on both timing variants
        xact(0, 1'b1, {4'd0, 2'd2}, 32'h0000_00A5, 0);
        xact(0, 1'b0, {4'd0, 2'd2}, 32'h0, 0);
        xact(0, 1'b1, {4'd1, 2'd0}, 32'h1234_5678, 0);
        xact(0, 1'b0, {4'd1, 2'd0}, 32'h0, 0);
        xact(1, 1'b1, {4'd1, 2'd0}, 32'h1234_5678, 3);
        xact(1, 1'b0, {4'd1, 2'd0}, 32'h0, 3);
        xact(1, 1'b0, {4'd9, 2'd1}, 32'h0, 3);

        // Unmapped device
        xact(0, 1'b0, {4'd9, 2'd0}, 32'h0, 0);
        xact(0, 1'b1, {4'd9, 2'd0}, 32'hFFFF_FFFF, 0);
        xact(0, 1'b0, {4'd9, 2'd0}, 32'h0, 0);

        // Mask / priority
        set_int(0, 4'b1100);
        xact(0, 1'b1, {4'hF, 2'd1}, 32'h0000_0006, 0);
        check_irq(0, "mask0110");
        check("mask0110_irq_val", irq[0], 1);
        check("mask0110_vec_val", vec[0], 2);
        xact(0, 1'b0, {4'hF, 2'd1}, 32'h0, 0);
        xact(0, 1'b1, {4'hF, 2'd1}, 32'h0, 0);
        check_irq(0, "mask0");
        check("mask0_irq_val", irq[0], 0);

        // Pending register
        xact(0, 1'b0, {4'hF, 2'd0}, 32'h0, 0);
        xact(0, 1'b0, {4'hF, 2'd0}, 32'h0, 0);
        set_int(0, 4'b0000);
        set_int(0, 4'b1000);
`ifdef IOBUS_IRQ_STICKY_EN
        set_int(0, 4'b0000);
`endif
        xact(0, 1'b0, {4'hF, 2'd0}, 32'h0, 0);
        check("pend_pulse_val", rdata[0], 32'h8);
`ifndef IOBUS_IRQ_STICKY_EN
        set_int(0, 4'b0000);
`endif
        xact(0, 1'b0, {4'hF, 2'd0}, 32'h0, 0);
        check("pend_second_val", rdata[0], 32'h0);
        xact(0, 1'b0, {4'hF, 2'd2}, 32'h0, 0);
        xact(0, 1'b1, {4'hF, 2'd3}, 32'h5555_5555, 0);
        xact(0, 1'b0, {4'hF, 2'd3}, 32'h0, 0);

        // Reset in the middle of a write strobe
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = {4'd2, 2'd3}; wdata[0] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("midrst_pre_en", pen[0], 4'b0100);
        #1 rst = 1'b1;
        #1;
        req[0] = 1'b0;
        check("midrst_en", pen[0], 0);
        check("midrst_write", pwrite[0], 0);
        check("midrst_ack", ack[0], 0);
        check("midrst_rdata", rdata[0], 0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin ref_mask[s] = '0; ref_pend[s] = '0; end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("midrst_no_ack", ack[0], 0);
        end
        check_irq(0, "midrst");
        xact(0, 1'b0, {4'd2, 2'd3}, 32'h0, 0);
        xact(0, 1'b1, {4'd2, 2'd3}, 32'hCAFE_F00D, 0);
        xact(0, 1'b0, {4'd2, 2'd3}, 32'h0, 0);

        // Randomised traffic against the reference model
        for (int n = 0; n < 40; n++) begin
`ifndef IOBUS_IRQ_STICKY_EN
            set_int(0, ND'($urandom_range(0, 15)));
`endif
            ra = 6'($urandom_range(0, 63));
            rw = 1'($urandom_range(0, 1));
            rd = $urandom;
            if ($urandom_range(0, 3) == 0) ra = {4'hF, 2'($urandom_range(0, 1))};
            xact(0, rw, ra, rd, 0);
            check_irq(0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
